bcd_counter: RTL

- Parametrised multi-digit BCD up/down counter.
- Generalises the single-digit BCD stage to NUM_DIGITS cascaded decades with direction, synchronous clear, parallel load and a selectable wrap/saturate mode.
- Sits between tick sources (prescalers, button debouncers) and display drivers in the example designs.
- Output is packed BCD, digit 0 in bits [3:0].

---
 rtl/bcd_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit packed-BCD up/down counter.
//
// Ports:
//   sys_clk      rising-edge system clock
//   sys_reset_n  asynchronous active-low reset
//   clear        synchronous clear to zero (highest priority)
//   load         synchronous parallel load of load_value (digits > 9 clamp to 9)
//   load_value   packed BCD load value, digit 0 in [3:0]
//   tick_up      increment request (ignored when tick_down is also high)
//   tick_down    decrement request (ignored when tick_up is also high)
//   count        registered packed BCD count
//   carry_out    registered one-cycle pulse on overflow past all nines
//   borrow_out   registered one-cycle pulse on underflow past zero
//   at_max       count is all nines
//   at_zero      count is zero
module bcd_counter #(
  parameter int NUM_DIGITS = 4,
  parameter bit WRAP       = 1'b1
) (
  input  logic                      sys_clk,
  input  logic                      sys_reset_n,
  input  logic                      clear,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  input  logic                      tick_up,
  input  logic                      tick_down,
  output logic [4*NUM_DIGITS-1:0]   count,
  output logic                      carry_out,
  output logic                      borrow_out,
  output logic                      at_max,
  output logic                      at_zero
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  logic [W-1:0] count_q, count_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] load_clamped;
  logic         cy;
  logic         bw;
  logic         max_now;
  logic         zero_now;

  assign max_now  = (count_q == ALL_NINES);
  assign zero_now = (count_q == '0);

  // Ripple increment/decrement resolved in a single cycle.
  always_comb begin
    inc_val      = count_q;
    dec_val      = count_q;
    load_clamped = load_value;
    cy           = 1'b1;
    bw           = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cy) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
      if (load_value[4*i +: 4] > 4'd9) begin
        load_clamped[4*i +: 4] = 4'd9;
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (tick_up && !tick_down) begin
      if (max_now) begin
        carry_d = 1'b1;
        count_d = WRAP ? '0 : ALL_NINES;
      end else begin
        count_d = inc_val;
      end
    end else if (tick_down && !tick_up) begin
      if (zero_now) begin
        borrow_d = 1'b1;
        count_d  = WRAP ? ALL_NINES : '0;
      end else begin
        count_d = dec_val;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign count      = count_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign at_max     = max_now;
  assign at_zero    = zero_now;

endmodule
